ledge_motion_ctrl: RTL
======================

Name: ledge_motion_ctrl

Overview:
- Frame-rate scheduler that animates NUM_LEDGES ledge platforms by computing each ledge's centre position once per video frame.
- Drives the ledgeX/ledgeY centre inputs of the per-ledge renderers (half-size 67x12).
- Positions are updated one ledge per clock in a working bank, then published atomically, so renderers and collision logic never see a half-updated frame.

Parameters:
- NUM_LEDGES, 3, number of ledges managed (1..8)
- X_MIN, 67, leftmost legal centre X
- X_MAX, 572, rightmost legal centre X
- STEP, 1, pixels moved per frame
- DWELL, 30, frames held at a turnaround bound
- SPACING, 160, initial X spacing: X_i = X_MIN + i*SPACING
- Y_BASE, 400, initial Y of ledge 0
- Y_STEP, 80, initial Y decrement per ledge: Y_i = Y_BASE - i*Y_STEP
- Y_AMP, 16, vertical bob amplitude (optional feature only)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  frame tick from VGA controller, asynchronous to Clk
- enable  in  1  motion enable; low = frame ticks ignored
- ledge_X_out  out  10*NUM_LEDGES  published centre X; ledge i at bits [10i+9:10i]
- ledge_Y_out  out  10*NUM_LEDGES  published centre Y, same packing
- ledge_dir  out  NUM_LEDGES  published direction per ledge; 1 = moving right
- update_busy  out  1  high while the FSM is not IDLE
- update_done  out  1  one-cycle pulse on publish
- overrun  out  1  sticky; set when a frame tick arrives while busy

Behaviour:
- Reset (async):
  - Working and published X_i/Y_i take their initial values.
  - dir_i = 1 for even i, 0 for odd i.
  - All dwell counters = 0.
  - FSM = IDLE; update_busy, update_done and overrun = 0.
- frame_clk path:
  - Two-flop synchroniser, then a third flop for rising-edge detect.
  - tick = sync2 & ~sync3.
- FSM states: IDLE, UPDATE, PUBLISH.
  - IDLE: on tick with enable=1, go to UPDATE with idx=0. A tick with enable=0 is discarded.
  - UPDATE: processes ledge idx in one cycle.
    - If idx==NUM_LEDGES-1, go to PUBLISH; otherwise idx+1.
  - PUBLISH: copy the working bank to the outputs, pulse update_done for this cycle, return to IDLE.
- Per-ledge update in UPDATE:
  - If dwell_i != 0: decrement dwell_i; X unchanged.
  - Else, moving right: if X_i + STEP >= X_MAX, set X_i = X_MAX, dir_i = 0, dwell_i = DWELL; otherwise X_i += STEP.
  - Else, moving left: if X_i <= X_MIN + STEP, set X_i = X_MIN, dir_i = 1, dwell_i = DWELL; otherwise X_i -= STEP.
  - Comparisons use 11-bit intermediates, so there is no wrap-around or underflow.
  - Every X stays within [X_MIN, X_MAX].
- Latency:
  - The UPDATE state is entered on the 3rd Clk edge after frame_clk rises.
  - Outputs change and update_done pulses NUM_LEDGES+1 cycles after UPDATE is entered: 7 cycles total for the default.
- Outputs change only on the PUBLISH edge.
- Simultaneous events:
  - A tick while in UPDATE or PUBLISH is dropped and sets overrun; the update in progress completes normally.
  - enable falling mid-update does not abort the update; it only gates future ticks.
- Reset mid-update: immediate return to initial state; no publish occurs.
- dwell_i is a per-ledge counter sized for DWELL and saturates at 0.

Optional Feature:
- LEDGE_VERTICAL_EN defined:
  - Odd-indexed ledges also bob vertically on every non-dwell frame: Y moves 1 pixel per frame between initial Y - Y_AMP and initial Y + Y_AMP.
  - A per-ledge vertical direction bit starts at 0 (moving up) and reverses at each limit.
  - Even ledges keep a fixed Y.
- LEDGE_VERTICAL_EN undefined:
  - Y_i is constant at its initial value.
  - No vertical-direction state is synthesised.

Test Plan:
- Reset, then 1 frame tick with enable=1 -> update_done pulses exactly once, 7 cycles after frame_clk rises; published X = {67->68, 227->226, 387->388}; Y = {400, 320, 240}; update_busy high for 4 cycles.
- 160 ticks -> ledge1 X = 67 with dir=1. Ticks 161..190 -> X1 held at 67. Tick 191 -> X1 = 68.
- 505 ticks -> ledge0 X = 572 with dir=0. The next 30 ticks hold X0 at 572. Tick 536 -> X0 = 571.
- Second frame_clk edge 2 cycles after the first -> overrun=1, exactly one publish. overrun stays 1 until Reset.
- enable=0 for 10 ticks -> no update_done pulses and outputs unchanged. enable=1 -> motion resumes from the held values.
- Assert Reset in the 2nd UPDATE cycle -> outputs return to initial values immediately, no update_done pulse. With LEDGE_VERTICAL_EN: 16 ticks -> Y1 = 304; 48 ticks -> Y1 = 336.

Source files
------------

// File: rtl/ledge_motion_ctrl.sv
// ledge_motion_ctrl: per-frame ledge position scheduler with atomic publish.
// Optional vertical bob of odd ledges enabled by defining LEDGE_VERTICAL_EN.
`default_nettype none

module ledge_motion_ctrl #(
   parameter int NUM_LEDGES = 3,
   parameter int X_MIN      = 67,
   parameter int X_MAX      = 572,
   parameter int STEP       = 1,
   parameter int DWELL      = 30,
   parameter int SPACING    = 160,
   parameter int Y_BASE     = 400,
   parameter int Y_STEP     = 80,
   parameter int Y_AMP      = 16
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       frame_clk,
   input  logic                       enable,
   output logic [10*NUM_LEDGES-1:0]   ledge_X_out,
   output logic [10*NUM_LEDGES-1:0]   ledge_Y_out,
   output logic [NUM_LEDGES-1:0]      ledge_dir,
   output logic                       update_busy,
   output logic                       update_done,
   output logic                       overrun
);

   localparam int IW = (NUM_LEDGES > 1) ? $clog2(NUM_LEDGES) : 1;
   localparam int DW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDGES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      UPDATE  = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   function automatic logic [9:0] init_x(input int i);
      return 10'(X_MIN + i * SPACING);
   endfunction

   function automatic logic [9:0] init_y(input int i);
      return 10'(Y_BASE - i * Y_STEP);
   endfunction

   function automatic logic [NUM_LEDGES-1:0] init_dir();
      logic [NUM_LEDGES-1:0] d;
      for (int i = 0; i < NUM_LEDGES; i++) d[i] = ~i[0];
      return d;
   endfunction

   // frame_clk crosses into Clk through two flops; third flop gives edge detect
   logic sync1, sync2, sync3, tick;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= frame_clk;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign tick = sync2 & ~sync3;

   state_t        state, state_nxt;
   logic [IW-1:0] idx, idx_nxt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (tick && enable) begin
               state_nxt = UPDATE;
               idx_nxt   = '0;
            end
         end
         UPDATE: begin
            if (idx == LAST_IDX) state_nxt = PUBLISH;
            else                 idx_nxt   = idx + IW'(1);
         end
         PUBLISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign update_busy = (state != IDLE);

   // working bank and published bank
   logic [9:0]            x_w   [NUM_LEDGES];
   logic [9:0]            x_pub [NUM_LEDGES];
   logic [DW-1:0]         dwell_w [NUM_LEDGES];
   logic [NUM_LEDGES-1:0] dir_w;

   logic [10:0]   cur_x;
   logic [9:0]    x_nxt;
   logic          dir_nxt;
   logic [DW-1:0] dwell_nxt;
   logic          moved;

   always_comb begin
      cur_x     = {1'b0, x_w[idx]};
      x_nxt     = x_w[idx];
      dir_nxt   = dir_w[idx];
      dwell_nxt = dwell_w[idx];
      moved     = 1'b0;
      if (dwell_w[idx] != '0) begin
         dwell_nxt = dwell_w[idx] - DW'(1);
      end else begin
         moved = 1'b1;
         if (dir_w[idx]) begin
            if (cur_x + 11'(STEP) >= 11'(X_MAX)) begin
               x_nxt     = 10'(X_MAX);
               dir_nxt   = 1'b0;
               dwell_nxt = DW'(DWELL);
            end else begin
               x_nxt = 10'(cur_x + 11'(STEP));
            end
         end else begin
            if (cur_x <= 11'(X_MIN + STEP)) begin
               x_nxt     = 10'(X_MIN);
               dir_nxt   = 1'b1;
               dwell_nxt = DW'(DWELL);
            end else begin
               x_nxt = 10'(cur_x - 11'(STEP));
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_LEDGES; i++) begin
            x_w[i]     <= init_x(i);
            x_pub[i]   <= init_x(i);
            dwell_w[i] <= '0;
         end
         dir_w       <= init_dir();
         ledge_dir   <= init_dir();
         update_done <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         update_done <= (state == PUBLISH);
         if (tick && (state != IDLE)) overrun <= 1'b1;
         if (state == UPDATE) begin
            x_w[idx]     <= x_nxt;
            dir_w[idx]   <= dir_nxt;
            dwell_w[idx] <= dwell_nxt;
         end
         if (state == PUBLISH) begin
            for (int i = 0; i < NUM_LEDGES; i++) x_pub[i] <= x_w[i];
            ledge_dir <= dir_w;
         end
      end
   end

   always_comb begin
      ledge_X_out = '0;
      for (int i = 0; i < NUM_LEDGES; i++) ledge_X_out[10*i +: 10] = x_pub[i];
   end

`ifdef LEDGE_VERTICAL_EN
   // odd ledges bob between init_y-Y_AMP and init_y+Y_AMP; vdir 0 = moving up
   logic [9:0]            y_w   [NUM_LEDGES];
   logic [9:0]            y_pub [NUM_LEDGES];
   logic [NUM_LEDGES-1:0] vdir_w;
   logic [10:0]           cur_y, y_lo, y_hi;
   logic [9:0]            y_nxt;
   logic                  vdir_nxt;

   always_comb begin
      cur_y    = {1'b0, y_w[idx]};
      y_lo     = 11'(int'(init_y(int'(idx))) - Y_AMP);
      y_hi     = 11'(int'(init_y(int'(idx))) + Y_AMP);
      y_nxt    = y_w[idx];
      vdir_nxt = vdir_w[idx];
      if (moved && idx[0]) begin
         if (!vdir_w[idx]) begin
            if (cur_y <= y_lo + 11'd1) begin
               y_nxt    = 10'(y_lo);
               vdir_nxt = 1'b1;
            end else begin
               y_nxt = 10'(cur_y - 11'd1);
            end
         end else begin
            if (cur_y + 11'd1 >= y_hi) begin
               y_nxt    = 10'(y_hi);
               vdir_nxt = 1'b0;
            end else begin
               y_nxt = 10'(cur_y + 11'd1);
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_LEDGES; i++) begin
            y_w[i]   <= init_y(i);
            y_pub[i] <= init_y(i);
         end
         vdir_w <= '0;
      end else begin
         if (state == UPDATE) begin
            y_w[idx]    <= y_nxt;
            vdir_w[idx] <= vdir_nxt;
         end
         if (state == PUBLISH) begin
            for (int i = 0; i < NUM_LEDGES; i++) y_pub[i] <= y_w[i];
         end
      end
   end

   always_comb begin
      ledge_Y_out = '0;
      for (int i = 0; i < NUM_LEDGES; i++) ledge_Y_out[10*i +: 10] = y_pub[i];
   end
`else
   logic unused_moved;
   assign unused_moved = moved;

   always_comb begin
      ledge_Y_out = '0;
      for (int i = 0; i < NUM_LEDGES; i++) ledge_Y_out[10*i +: 10] = init_y(i);
   end
`endif

endmodule

`default_nettype wire
